// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_t;

    // Magnitude of a sign-extended operand; the most-negative value maps to its unsigned magnitude.
    function automatic logic [31:0] magnitude(input logic signed [31:0] v);
        return v[31] ? $unsigned(-v) : $unsigned(v);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring shift-subtract step of the divider.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] prem,
    input  logic             nbit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] prem_next,
    output logic             qbit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // prem < divisor always holds, so a non-negative trial never exceeds WIDTH bits
    // and its MSB alone tells whether the subtraction succeeded.
    assign shifted   = {prem, nbit};
    assign trial     = shifted - {1'b0, divisor};
    assign qbit      = ~trial[WIDTH];
    assign prem_next = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned integer divider with a start/busy/done handshake.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic busy_nxt, done_nxt;
    logic accept, dz_in, ov_in, last_step;

    logic signed [WIDTH-1:0] dividend_s, divisor_s;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;

    logic [WIDTH-1:0] prem, qsh, dvs;
    logic q_neg, r_neg, ov_pend;
    logic [WIDTH-1:0] prem_next, q_final;
    logic qbit;

    assign dividend_s = dividend;
    assign divisor_s  = divisor;
    assign dvd_mag = op_signed ? WIDTH'(magnitude(32'(dividend_s))) : dividend;
    assign dvs_mag = op_signed ? WIDTH'(magnitude(32'(divisor_s)))  : divisor;

    assign accept    = (state == IDLE) && start;
    assign dz_in     = (divisor == '0);
    assign ov_in     = op_signed && (dividend == MOST_NEG) && (&divisor);
    assign last_step = (state == RUN) && (cnt == CW'(1));
    assign q_final   = {qsh[WIDTH-2:0], qbit};

    div_step #(.WIDTH(WIDTH)) u_step (
        .prem      (prem),
        .nbit      (qsh[WIDTH-1]),
        .divisor   (dvs),
        .prem_next (prem_next),
        .qbit      (qbit)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = dz_in ? DONE : RUN;
            RUN:  if (cnt == CW'(1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // busy and done are registered, so they trail the state by one edge
        // except that busy rises on the accepting edge itself.
        busy_nxt = (state != IDLE) || accept;
        done_nxt = (state == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            if (accept) begin
                cnt <= dz_in ? '0 : CNT_INIT;
            end else if (state == RUN) begin
                cnt <= cnt - 1'b1;
            end
            if (accept && dz_in) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
                overflow    <= 1'b0;
            end else if (last_step) begin
                quotient    <= q_neg ? -q_final : q_final;
                remainder   <= r_neg ? -prem_next : prem_next;
                div_by_zero <= 1'b0;
                overflow    <= ov_pend;
            end
        end
    end

    // operand capture (_p0) and per-step datapath; no reset needed on data
    always_ff @(posedge clock) begin
        if (accept) begin
            prem    <= '0;
            qsh     <= dvd_mag;
            dvs     <= dvs_mag;
            q_neg   <= op_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg   <= op_signed && dividend[WIDTH-1];
            ov_pend <= ov_in;
        end else if (state == RUN) begin
            prem <= prem_next;
            qsh  <= q_final;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider at WIDTH=4 and WIDTH=8.
module tb_seq_divider;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic       start4, sgn4, busy4, done4, dz4, ov4;
    logic [3:0] a4, b4, q4, r4;
    logic       start8, sgn8, busy8, done8, dz8, ov8;
    logic [7:0] a8, b8, q8, r8;

    seq_divider #(.WIDTH(4)) dut4 (
        .clock(clock), .reset(reset), .start(start4), .op_signed(sgn4),
        .dividend(a4), .divisor(b4), .busy(busy4), .done(done4),
        .quotient(q4), .remainder(r4), .div_by_zero(dz4), .overflow(ov4)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .op_signed(sgn8),
        .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
        .quotient(q8), .remainder(r8), .div_by_zero(dz8), .overflow(ov8)
    );

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Reference: native truncating division on sign-extended integers.
    function automatic exp_t model(input int w, input bit sgn, input logic [7:0] ain, input logic [7:0] bin);
        exp_t e;
        longint mask, half, a, b, sa, sbv;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        a = longint'(ain) & mask;
        b = longint'(bin) & mask;
        e.dz = 1'b0;
        e.ov = 1'b0;
        if (b == 0) begin
            e.q = 8'(mask); e.r = 8'(a); e.dz = 1'b1;
        end else if (sgn) begin
            sa  = (a ^ half) - half;
            sbv = (b ^ half) - half;
            if (sa == -half && sbv == -1) begin
                e.q = 8'(a); e.r = 8'd0; e.ov = 1'b1;
            end else begin
                e.q = 8'((sa / sbv) & mask);
                e.r = 8'((sa % sbv) & mask);
            end
        end else begin
            e.q = 8'(a / b); e.r = 8'(a % b);
        end
        return e;
    endfunction

    task automatic issue(input int w, input bit sgn, input logic [7:0] a, input logic [7:0] b);
        if (w == 4) begin
            sgn4 = sgn; a4 = a[3:0]; b4 = b[3:0]; start4 = 1'b1;
        end else begin
            sgn8 = sgn; a8 = a; b8 = b; start8 = 1'b1;
        end
        sb.push_back(model(w, sgn, a, b));
        @(posedge clock); #1;
        start4 = 1'b0;
        start8 = 1'b0;
    endtask

    // Samples once per cycle from now until busy drops (bounded); reports timing only.
    task automatic run(input int w, output int done_at, output int busy_cyc, output int done_cnt);
        logic bs, ds;
        done_at = -1; busy_cyc = 0; done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            bs = (w == 4) ? busy4 : busy8;
            ds = (w == 4) ? done4 : done8;
            if (bs) busy_cyc++;
            if (ds) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (!bs) break;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start4 = 0; sgn4 = 0; a4 = 4'h5; b4 = 4'h3;
        start8 = 0; sgn8 = 0; a8 = 8'h5; b8 = 8'h3;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if ({busy4, done4, q4, r4, dz4, ov4} !== 12'h0)
            $display("FAIL reset4 got busy=%b done=%b q=%h r=%h dz=%b ov=%b, expected all 0", busy4, done4, q4, r4, dz4, ov4);
        else n_pass++;
        n_checks++;
        if ({busy8, done8, q8, r8, dz8, ov8} !== 20'h0)
            $display("FAIL reset8 got busy=%b done=%b q=%h r=%h dz=%b ov=%b, expected all 0", busy8, done8, q8, r8, dz8, ov8);
        else n_pass++;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_unsigned;
        exp_t e; int da, bc, dc;
        issue(4, 0, 8'd13, 8'd4);
        run(4, da, bc, dc);
        e = sb.pop_front();
        n_checks++;
        if (da !== 5) $display("FAIL latency4 done_at=%0d expected 5", da); else n_pass++;
        n_checks++;
        if (bc !== 6) $display("FAIL busy4_len got %0d expected 6", bc); else n_pass++;
        n_checks++;
        if (dc !== 1) $display("FAIL done4_pulse got %0d cycles expected 1", dc); else n_pass++;
        n_checks++;
        if ({q4, r4, dz4, ov4} !== {e.q[3:0], e.r[3:0], e.dz, e.ov})
            $display("FAIL u13div4 got q=%h r=%h dz=%b ov=%b expected q=%h r=%h dz=%b ov=%b", q4, r4, dz4, ov4, e.q[3:0], e.r[3:0], e.dz, e.ov);
        else n_pass++;
    endtask

    task automatic test_signed;
        exp_t e; int da, bc, dc;
        logic [7:0] ta [2] = '{8'h09, 8'h07};
        logic [7:0] tb [2] = '{8'h02, 8'h0E};
        for (int k = 0; k < 2; k++) begin
            issue(4, 1, ta[k], tb[k]);
            run(4, da, bc, dc);
            e = sb.pop_front();
            n_checks++;
            if (da != 5 || {q4, r4, dz4, ov4} !== {e.q[3:0], e.r[3:0], e.dz, e.ov})
                $display("FAIL signed4_%0d got q=%h r=%h dz=%b ov=%b done_at=%0d expected q=%h r=%h dz=%b ov=%b done_at=5", k, q4, r4, dz4, ov4, da, e.q[3:0], e.r[3:0], e.dz, e.ov);
            else n_pass++;
        end
    endtask

    task automatic test_div_zero_back_to_back;
        exp_t e; int da, bc, dc;
        issue(4, 0, 8'd9, 8'd0);
        @(posedge clock); #1;
        e = sb.pop_front();
        n_checks++;
        if (done4 !== 1'b1 || {q4, r4, dz4, ov4} !== {e.q[3:0], e.r[3:0], e.dz, e.ov})
            $display("FAIL divzero4 got done=%b q=%h r=%h dz=%b ov=%b expected done=1 q=%h r=%h dz=%b ov=%b", done4, q4, r4, dz4, ov4, e.q[3:0], e.r[3:0], e.dz, e.ov);
        else n_pass++;
        // the done cycle of a divide-by-zero is already able to accept
        issue(4, 0, 8'd6, 8'd3);
        run(4, da, bc, dc);
        e = sb.pop_front();
        n_checks++;
        if (da != 5 || {q4, r4, dz4, ov4} !== {e.q[3:0], e.r[3:0], e.dz, e.ov})
            $display("FAIL b2b_6div3 got q=%h r=%h dz=%b ov=%b done_at=%0d expected q=%h r=%h dz=%b ov=%b done_at=5", q4, r4, dz4, ov4, da, e.q[3:0], e.r[3:0], e.dz, e.ov);
        else n_pass++;
    endtask

    task automatic test_overflow;
        exp_t e; int da, bc, dc;
        issue(4, 1, 8'h08, 8'h0F);
        run(4, da, bc, dc);
        e = sb.pop_front();
        n_checks++;
        if (da != 5 || {q4, r4, dz4, ov4} !== {e.q[3:0], e.r[3:0], e.dz, e.ov})
            $display("FAIL overflow4 got q=%h r=%h dz=%b ov=%b expected q=%h r=%h dz=%b ov=%b", q4, r4, dz4, ov4, e.q[3:0], e.r[3:0], e.dz, e.ov);
        else n_pass++;
        issue(4, 1, 8'd6, 8'd3);
        run(4, da, bc, dc);
        e = sb.pop_front();
        n_checks++;
        if ({q4, r4, dz4, ov4} !== {e.q[3:0], e.r[3:0], e.dz, e.ov})
            $display("FAIL flags_clear got q=%h r=%h dz=%b ov=%b expected q=%h r=%h dz=%b ov=%b", q4, r4, dz4, ov4, e.q[3:0], e.r[3:0], e.dz, e.ov);
        else n_pass++;
    endtask

    task automatic test_start_ignored;
        exp_t e; int da, bc, dc, extra;
        issue(4, 0, 8'd15, 8'd15);
        for (int k = 0; k < 3; k++) begin
            start4 = 1'b1; sgn4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
            @(posedge clock); #1;
        end
        start4 = 1'b0;
        run(4, da, bc, dc);
        e = sb.pop_front();
        n_checks++;
        if (da != 2 || {q4, r4, dz4, ov4} !== {e.q[3:0], e.r[3:0], e.dz, e.ov})
            $display("FAIL busy_start got q=%h r=%h done_at=%0d expected q=%h r=%h done_at=2", q4, r4, da, e.q[3:0], e.r[3:0]);
        else n_pass++;
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            if (busy4 || done4) extra++;
            @(posedge clock); #1;
        end
        n_checks++;
        if (extra !== 0) $display("FAIL no_queue got %0d busy/done cycles expected 0", extra); else n_pass++;
    endtask

    task automatic test_reset_mid_run;
        exp_t e; int da, bc, dc, seen;
        issue(4, 0, 8'd13, 8'd4);
        repeat (2) begin @(posedge clock); #1; end
        reset = 1'b1;
        #1;
        e = sb.pop_back();
        n_checks++;
        if ({busy4, done4, q4, r4, dz4, ov4} !== 12'h0)
            $display("FAIL reset_mid got busy=%b done=%b q=%h r=%h dz=%b ov=%b expected all 0", busy4, done4, q4, r4, dz4, ov4);
        else n_pass++;
        @(posedge clock); #1;
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (done4 || busy4) seen++;
            @(posedge clock); #1;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL abort_nodone got %0d active cycles expected 0", seen); else n_pass++;
        issue(4, 1, 8'd7, 8'h0E);
        run(4, da, bc, dc);
        e = sb.pop_front();
        n_checks++;
        if (da != 5 || {q4, r4, dz4, ov4} !== {e.q[3:0], e.r[3:0], e.dz, e.ov})
            $display("FAIL after_reset got q=%h r=%h done_at=%0d expected q=%h r=%h done_at=5", q4, r4, da, e.q[3:0], e.r[3:0]);
        else n_pass++;
    endtask

    task automatic test_width8;
        exp_t e; int da, bc, dc;
        bit sg; logic [7:0] a, b;
        issue(8, 0, 8'd255, 8'd16);
        run(8, da, bc, dc);
        e = sb.pop_front();
        n_checks++;
        if (da != 9 || {q8, r8, dz8, ov8} !== {8'd15, 8'd15, 1'b0, 1'b0})
            $display("FAIL u255div16 got q=%h r=%h done_at=%0d expected q=0f r=0f done_at=9", q8, r8, da);
        else n_pass++;
        issue(8, 1, 8'h80, 8'd3);
        run(8, da, bc, dc);
        e = sb.pop_front();
        n_checks++;
        if ({q8, r8, dz8, ov8} !== {8'hD6, 8'hFE, 1'b0, 1'b0})
            $display("FAIL sm128div3 got q=%h r=%h dz=%b ov=%b expected q=d6 r=fe dz=0 ov=0", q8, r8, dz8, ov8);
        else n_pass++;
        for (int k = 0; k < 300; k++) begin
            sg = 1'($urandom_range(0, 1));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            if (k == 0) begin a = 8'h80; b = 8'hFF; sg = 1'b1; end
            issue(8, sg, a, b);
            run(8, da, bc, dc);
            e = sb.pop_front();
            n_checks++;
            if (da != (e.dz ? 1 : 9) || {q8, r8, dz8, ov8} !== {e.q, e.r, e.dz, e.ov})
                $display("FAIL sweep8 op=%0d sgn=%b %h/%h got q=%h r=%h dz=%b ov=%b done_at=%0d expected q=%h r=%h dz=%b ov=%b",
                         k, sg, a, b, q8, r8, dz8, ov8, da, e.q, e.r, e.dz, e.ov);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero_back_to_back();
        test_overflow();
        test_start_ignored();
        test_reset_mid_run();
        test_width8();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
